// File: rtl/invo_freq_meter_if.sv
// Control/result bus between the test logic (master) and invo_freq_meter (slave).
interface invo_freq_meter_if #(
    parameter int CW = 16
);
    logic          START;
    logic          BUSY;
    logic          DONE;
    logic [CW-1:0] COUNT;
    logic          OVF;

    modport master (output START, input BUSY, DONE, COUNT, OVF);
    modport slave  (input START, output BUSY, DONE, COUNT, OVF);
endinterface

// File: rtl/invo_freq_meter.sv
// Ring-oscillator frequency meter: init, release, settle, then count edges over a gate window.
// Optional continuous measurement mode is enabled by defining INVO_MEAS_CONT_EN.
module invo_freq_meter #(
    parameter int INIT_CYC   = 5,
    parameter int SETTLE_CYC = 4,
    parameter int GATE_CYC   = 1024,
    parameter int CW         = 16
) (
    input  logic             CLK_ext,
    input  logic             RSTn,
    input  logic             OSC_IN,
    output logic             OSC_INIT,
    invo_freq_meter_if.slave bus
);

    localparam int MAX_IS  = (INIT_CYC > SETTLE_CYC) ? INIT_CYC : SETTLE_CYC;
    localparam int MAX_CYC = (MAX_IS > GATE_CYC) ? MAX_IS : GATE_CYC;
    localparam int PW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {IDLE, INIT, SETTLE, GATE, REPORT} state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] phase;
    logic          phase_end;
    logic          s1, s2, s3;
    logic          rise;
    logic [CW-1:0] edge_cnt;
    logic [CW-1:0] edge_inc;
    logic          ovf_flag;
    logic          ovf_inc;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          osc_init_c;
    logic          busy_c;
    logic          done_c;

    // Oscillator output is asynchronous; s3 only serves rising-edge detection.
    always_ff @(posedge CLK_ext or negedge RSTn) begin
        if (!RSTn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= OSC_IN;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    always_ff @(posedge CLK_ext or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || state == IDLE)
                phase <= '0;
            else
                phase <= phase + PW'(1);
        end
    end

    always_comb begin
        state_next = state;
        phase_end  = 1'b0;
        osc_init_c = 1'b0;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                osc_init_c = 1'b1;
                busy_c     = 1'b0;
                if (bus.START)
                    state_next = INIT;
            end
            INIT: begin
                osc_init_c = 1'b1;
                phase_end  = (phase == PW'(INIT_CYC - 1));
                if (phase_end)
                    state_next = SETTLE;
            end
            SETTLE: begin
                phase_end = (phase == PW'(SETTLE_CYC - 1));
                if (phase_end)
                    state_next = GATE;
            end
            GATE: begin
                phase_end = (phase == PW'(GATE_CYC - 1));
                if (phase_end)
                    state_next = REPORT;
            end
            REPORT: begin
                done_c = 1'b1;
`ifdef INVO_MEAS_CONT_EN
                state_next = bus.START ? GATE : IDLE;
`else
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Saturating increment; overflow means a rise arrived while already at all-ones.
    always_comb begin
        edge_inc = edge_cnt;
        ovf_inc  = ovf_flag;
        if (rise) begin
            if (&edge_cnt)
                ovf_inc = 1'b1;
            else
                edge_inc = edge_cnt + CW'(1);
        end
    end

    // The result registers load with the final gate-cycle value so they are valid during REPORT.
    always_ff @(posedge CLK_ext or negedge RSTn) begin
        if (!RSTn) begin
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (state == GATE) begin
            edge_cnt <= edge_inc;
            ovf_flag <= ovf_inc;
            if (phase_end) begin
                count_q <= edge_inc;
                ovf_q   <= ovf_inc;
            end
        end else begin
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
        end
    end

    assign OSC_INIT  = osc_init_c;
    assign bus.BUSY  = busy_c;
    assign bus.DONE  = done_c;
    assign bus.COUNT = count_q;
    assign bus.OVF   = ovf_q;

endmodule
